// File: rtl/mem_arbiter_pkg.sv
// Shared FSM state encoding and requester ids for the memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin pick: a lone requester wins outright, a tie goes
// to whichever port did not win last time.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = OWN_CPU;
    if (&req) begin
      winner = ~last;
    end else if (req[OWN_DBG]) begin
      winner = OWN_DBG;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a debug/loader port onto one single-ported memory.
// Grant one cycle after sampling; read data returned one cycle after grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q;
  logic              last_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0]        elig;
  logic              win;
  logic              win_vld;
  logic              win_we_d;
  logic [ADDR_W-1:0] win_addr_d;
  logic [DATA_W-1:0] win_wdata_d;

  // The lock only gates fresh CPU arbitration; an in-flight CPU access runs on.
  assign elig = {dbg_req, cpu_req & ~dbg_lock};

  rr_arb2 u_rr_arb2 (
    .req    (elig),
    .last   (last_q),
    .winner (win),
    .valid  (win_vld)
  );

  assign win_we_d    = (win == OWN_DBG) ? dbg_we    : cpu_we;
  assign win_addr_d  = (win == OWN_DBG) ? dbg_addr  : cpu_addr;
  assign win_wdata_d = (win == OWN_DBG) ? dbg_wdata : cpu_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= OWN_DBG;
      owner_q <= OWN_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            state_q <= ST_ISSUE;
            owner_q <= win;
            last_q  <= win;
            we_q    <= win_we_d;
            addr_q  <= win_addr_d;
            wdata_q <= win_wdata_d;
          end
        end
        ST_ISSUE: state_q <= we_q ? ST_IDLE : ST_RESP;
        ST_RESP:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Address/data registers only move on a pick, so they hold between accesses.
  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign cpu_gnt    = mem_en & (owner_q == OWN_CPU);
  assign dbg_gnt    = mem_en & (owner_q == OWN_DBG);
  assign cpu_rvalid = (state_q == ST_RESP) & (owner_q == OWN_CPU);
  assign dbg_rvalid = (state_q == ST_RESP) & (owner_q == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

  assign cpu_stall  = cpu_req & ~cpu_gnt;

endmodule
